rc6_job_scheduler: RTL
======================

# rc6_job_scheduler

Two-requester job scheduler in front of the RC6 encryption coprocessor (128-bit block, 256-bit key). Arbitrates round-robin between two independent request channels and sequences the core's key-write and data-write strobes around its busy flag. Returns each ciphertext on a valid/ready response channel tagged with the requester id. Optionally skips key expansion when the next job reuses the last loaded key.

## Interface
- BUSY_GAP, 2: cycles after a core strobe before `inCoreBusy` is sampled; legal 1..15.
- inClk  in  1  clock; all logic on rising edge.
- inReset  in  1  synchronous, active-high reset.
- inReqValid0 / inReqValid1  in  1  request pending on channel 0 / 1.
- outReqReady0 / outReqReady1  out  1  channel accepted this cycle when valid & ready.
- inReqKey0 / inReqKey1  in  256  job key.
- inReqData0 / inReqData1  in  128  job plaintext.
- outRspValid  out  1  result available.
- inRspReady  in  1  consumer accepts result.
- outRspId  out  1  requester id of result.
- outRspData  out  128  ciphertext.
- outCoreKeyWr / outCoreDataWr  out  1  one-cycle strobes to core.
- outCoreKey  out  256  key to core, held stable for the whole job.
- outCoreData  out  128  plaintext to core, held stable for the whole job.
- inCoreBusy  in  1  core busy flag.
- inCoreData  in  128  core result.
- outIdle  out  1  high in IDLE only.

## Operation
- States: IDLE, KEY_WR, KEY_WAIT, DATA_WR, DATA_WAIT, RESP.
- IDLE: grant = valid channel; if both valid, channel != lastGrant. `outReqReadyN = (state==IDLE) & grantN` (combinational). On accept: latch key, data, id; lastGrant <= id; go KEY_WR (or DATA_WR on cache hit).
- KEY_WR: `outCoreKeyWr`=1 one cycle -> KEY_WAIT.
- KEY_WAIT / DATA_WAIT: 4-bit gap counter loads BUSY_GAP-1 on entry, counts down; at 0, when `inCoreBusy`==0 -> DATA_WR / capture.
- DATA_WR: `outCoreDataWr`=1 one cycle -> DATA_WAIT.
- DATA_WAIT exit: `outRspData` <= `inCoreData`, `outRspId` <= latched id -> RESP.
- RESP: `outRspValid`=1 held, data/id stable until `inRspReady`; on handshake -> IDLE. No request accepted while in RESP.
- New request valid during non-IDLE states: ignored (ready low), served later; no drop.
- Reset values: state IDLE, all strobes 0, `outRspValid` 0, `outRspId` 0, `outRspData` 0, `outCoreKey`/`outCoreData` 0, lastGrant 1 (channel 0 wins first tie), key-cache valid 0, `outIdle` 1.
- Reset mid-job: job discarded, no response emitted; core shares `inReset` so no partial state survives.

## Timing
- Accept at cycle 0 -> KEY_WR strobe cycle 1 -> KEY_WAIT from cycle 2, earliest exit cycle 2+BUSY_GAP.
- Cache hit: DATA_WR strobe cycle 1.
- Response valid the cycle after DATA_WAIT exit; back-to-back: next accept is the cycle after the RESP handshake.
- Strobes never overlap; exactly one `outCoreKeyWr` (or zero on hit) and one `outCoreDataWr` per job.

## Configuration
- RC6_KEY_CACHE_EN defined: 256-bit last-key register + valid bit, set on KEY_WR; accept with key equal to cached key and valid=1 goes IDLE -> DATA_WR. Reset clears valid.
- Undefined: no cache register; every job passes KEY_WR/KEY_WAIT.

## Test plan
- Single job ch0, key 0, plaintext 0, BUSY_GAP=2, core model busy 5 cycles -> one key strobe, one data strobe, `outRspId`=0, data = model output, `outIdle` returns 1.
- Both channels valid continuously, 4 jobs -> grant order 0,1,0,1; each response id matches.
- `inRspReady` held low 10 cycles in RESP -> `outRspValid`, data, id stable; both ready outputs low throughout.
- With RC6_KEY_CACHE_EN: two jobs, same key -> second job has no `outCoreKeyWr`, latency shortened by 1+key-busy cycles; different key -> key strobe issued. Without macro: key strobe on both.
- `inReset` asserted in DATA_WAIT -> next cycle state IDLE, `outRspValid`=0, cache invalid; subsequent job completes normally.
- `inCoreBusy` low for first BUSY_GAP cycles after strobe then high -> scheduler waits for fall, does not exit early.

Source files
------------

// File: rtl/rc6_job_scheduler.sv
// Two-channel round-robin job scheduler in front of an RC6 core (256-bit key, 128-bit block).
// Optional last-key cache enabled by defining RC6_KEY_CACHE_EN.
module rc6_job_scheduler #(
    parameter int BUSY_GAP = 2
) (
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inReqValid0,
    input  logic         inReqValid1,
    output logic         outReqReady0,
    output logic         outReqReady1,
    input  logic [255:0] inReqKey0,
    input  logic [255:0] inReqKey1,
    input  logic [127:0] inReqData0,
    input  logic [127:0] inReqData1,
    output logic         outRspValid,
    input  logic         inRspReady,
    output logic         outRspId,
    output logic [127:0] outRspData,
    output logic         outCoreKeyWr,
    output logic         outCoreDataWr,
    output logic [255:0] outCoreKey,
    output logic [127:0] outCoreData,
    input  logic         inCoreBusy,
    input  logic [127:0] inCoreData,
    output logic         outIdle
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_WR    = 3'd1,
        KEY_WAIT  = 3'd2,
        DATA_WR   = 3'd3,
        DATA_WAIT = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(BUSY_GAP - 1);

    state_t        state_r;
    state_t        state_n;
    logic          last_grant_r;
    logic          id_r;
    logic [3:0]    gap_r;
    logic          grant0_s;
    logic          grant1_s;
    logic          accept_s;
    logic          hit_s;
    logic          gap_done_s;
    logic [255:0]  sel_key_s;
    logic [127:0]  sel_data_s;

    // Round-robin grant: on a tie the channel that did not win last time goes.
    assign grant0_s     = inReqValid0 & (~inReqValid1 | last_grant_r);
    assign grant1_s     = inReqValid1 & (~inReqValid0 | ~last_grant_r);
    assign outReqReady0 = (state_r == IDLE) & grant0_s;
    assign outReqReady1 = (state_r == IDLE) & grant1_s;
    assign accept_s     = outReqReady0 | outReqReady1;
    assign sel_key_s    = grant1_s ? inReqKey1 : inReqKey0;
    assign sel_data_s   = grant1_s ? inReqData1 : inReqData0;
    assign gap_done_s   = (gap_r == 4'd0) & ~inCoreBusy;

`ifdef RC6_KEY_CACHE_EN
    logic [255:0] cache_key_r;
    logic         cache_valid_r;

    assign hit_s = cache_valid_r & (sel_key_s == cache_key_r);

    // Last-loaded key register; valid only once the core has actually taken the key.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            cache_key_r   <= 256'd0;
            cache_valid_r <= 1'b0;
        end else if (state_r == KEY_WR) begin
            cache_key_r   <= outCoreKey;
            cache_valid_r <= 1'b1;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = hit_s ? DATA_WR : KEY_WR;
                end else begin
                    state_n = IDLE;
                end
            end
            KEY_WR:   state_n = KEY_WAIT;
            KEY_WAIT: begin
                if (gap_done_s) begin
                    state_n = DATA_WR;
                end else begin
                    state_n = KEY_WAIT;
                end
            end
            DATA_WR:  state_n = DATA_WAIT;
            DATA_WAIT: begin
                if (gap_done_s) begin
                    state_n = RESP;
                end else begin
                    state_n = DATA_WAIT;
                end
            end
            RESP: begin
                if (inRspReady) begin
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default:  state_n = IDLE;
        endcase
    end

    // State register and registered strobes/flags decoded from the next state.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_r       <= IDLE;
            outCoreKeyWr  <= 1'b0;
            outCoreDataWr <= 1'b0;
            outRspValid   <= 1'b0;
            outIdle       <= 1'b1;
        end else begin
            state_r       <= state_n;
            outCoreKeyWr  <= (state_n == KEY_WR);
            outCoreDataWr <= (state_n == DATA_WR);
            outRspValid   <= (state_n == RESP);
            outIdle       <= (state_n == IDLE);
        end
    end

    // Job capture on accept; key and plaintext stay on the core ports for the whole job.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            outCoreKey   <= 256'd0;
            outCoreData  <= 128'd0;
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            outCoreKey   <= sel_key_s;
            outCoreData  <= sel_data_s;
            id_r         <= grant1_s;
            last_grant_r <= grant1_s;
        end
    end

    // Busy-sample gap: loaded while the strobe is out, counts down in the wait states.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            gap_r <= 4'd0;
        end else if ((state_r == KEY_WR) || (state_r == DATA_WR)) begin
            gap_r <= GAP_LOAD;
        end else if (((state_r == KEY_WAIT) || (state_r == DATA_WAIT)) && (gap_r != 4'd0)) begin
            gap_r <= gap_r - 4'd1;
        end
    end

    // Response capture when the core finishes the data phase.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            outRspData <= 128'd0;
            outRspId   <= 1'b0;
        end else if ((state_r == DATA_WAIT) && gap_done_s) begin
            outRspData <= inCoreData;
            outRspId   <= id_r;
        end
    end

endmodule
